// File: rtl/perceptron_trainer.sv
// Training controller for perceptron_dp. It loads the initial binary weights and streams labelled samples.
// On each miss it applies the binary-weight perceptron rule, and it stops on an error-free epoch or at the epoch limit.
module perceptron_trainer #(
  parameter int         WIDTH      = 8,
  parameter int         DP_LATENCY = 1,
  parameter int         EPOCH_LEN  = 4,
  parameter int         MAX_EPOCHS = 16,
  parameter logic [2:0] INIT_W1W0B = 3'b111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             smp_valid_i,
  output logic             smp_ready_o,
  input  logic [WIDTH-1:0] smp_x0_i,
  input  logic [WIDTH-1:0] smp_x1_i,
  input  logic             smp_t_i,
  output logic             enable_o,
  output logic [1:0]       W1W0b_en_o,
  output logic             b_o,
  output logic             W0_o,
  output logic             W1_o,
  output logic [WIDTH-1:0] X0_o,
  output logic [WIDTH-1:0] X1_o,
  input  logic             Y_i,
  output logic             busy_o,
  output logic             converged_o,
  output logic [4:0]       epoch_cnt_o,
  output logic [7:0]       err_cnt_o
);

  localparam int IW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam int CW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(EPOCH_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DP_LATENCY - 1);
  localparam logic [4:0]    EPOCH_MAX = 5'(MAX_EPOCHS);

  typedef enum logic [3:0] {
    ST_LD_B, ST_LD_W0, ST_LD_W1, ST_IDLE, ST_FETCH, ST_EVAL,
    ST_WAIT, ST_CHECK, ST_UPD, ST_NEXT, ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
  logic             t_q, t_d;
  logic [2:0]       w_q, w_d;       // shadow {W1,W0,b} as held by the datapath
  logic [2:0]       new_q, new_d;   // rule result for the current miss
  logic [2:0]       mask_q, mask_d; // registers still to be reloaded
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       epoch_q, epoch_d;
  logic [7:0]       err_q, err_d;
  logic             conv_q, conv_d;
  logic [2:0]       rule;
  logic [4:0]       epoch_inc;

  assign X0_o        = x0_q;
  assign X1_o        = x1_q;
  assign epoch_cnt_o = epoch_q;
  assign err_cnt_o   = err_q;
  assign converged_o = conv_q;

  assign rule      = {t_q ~^ ~x1_q[WIDTH-1], t_q ~^ ~x0_q[WIDTH-1], t_q};
  assign epoch_inc = (epoch_q == EPOCH_MAX) ? epoch_q : epoch_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    t_d         = t_q;
    w_d         = w_q;
    new_d       = new_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    epoch_d     = epoch_q;
    err_d       = err_q;
    conv_d      = conv_q;
    smp_ready_o = 1'b0;
    enable_o    = 1'b0;
    W1W0b_en_o  = 2'b00;
    b_o         = 1'b0;
    W0_o        = 1'b0;
    W1_o        = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      ST_LD_B:  begin W1W0b_en_o = 2'b01; b_o  = w_q[0]; state_d = ST_LD_W0; end
      ST_LD_W0: begin W1W0b_en_o = 2'b10; W0_o = w_q[1]; state_d = ST_LD_W1; end
      ST_LD_W1: begin W1W0b_en_o = 2'b11; W1_o = w_q[2]; state_d = ST_IDLE;  end
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          idx_d   = '0;
          epoch_d = '0;
          err_d   = '0;
          conv_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy_o      = 1'b1;
        smp_ready_o = 1'b1;
        if (smp_valid_i) begin
          x0_d    = smp_x0_i;
          x1_d    = smp_x1_i;
          t_d     = smp_t_i;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        busy_o   = 1'b1;
        enable_o = 1'b1;
        cnt_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_CHECK;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_CHECK: begin
        busy_o  = 1'b1;
        state_d = ST_NEXT;
        if (Y_i != t_q) begin
          err_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          new_d  = rule;
          mask_d = rule ^ w_q;
          if ((rule ^ w_q) != 3'b000) state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        // One reload per cycle, b first, then W0, then W1; unchanged ones are skipped.
        busy_o = 1'b1;
        if (mask_q[0]) begin
          W1W0b_en_o = 2'b01; b_o  = new_q[0]; w_d[0] = new_q[0]; mask_d[0] = 1'b0;
        end else if (mask_q[1]) begin
          W1W0b_en_o = 2'b10; W0_o = new_q[1]; w_d[1] = new_q[1]; mask_d[1] = 1'b0;
        end else if (mask_q[2]) begin
          W1W0b_en_o = 2'b11; W1_o = new_q[2]; w_d[2] = new_q[2]; mask_d[2] = 1'b0;
        end
        if (mask_d == 3'b000) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        busy_o  = 1'b1;
        state_d = ST_FETCH;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          epoch_d = epoch_inc;
          if (err_q == 8'd0) begin
            conv_d  = 1'b1;
            state_d = ST_DONE;
          end else if (epoch_inc == EPOCH_MAX) begin
            state_d = ST_DONE;
          end else begin
            err_d = '0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_LD_B;
    endcase
    if (reset) begin
      smp_ready_o = 1'b0;
      enable_o    = 1'b0;
      W1W0b_en_o  = 2'b00;
      b_o         = 1'b0;
      W0_o        = 1'b0;
      W1_o        = 1'b0;
      busy_o      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LD_B;
      x0_q    <= '0;
      x1_q    <= '0;
      t_q     <= 1'b0;
      w_q     <= INIT_W1W0B;
      new_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      epoch_q <= '0;
      err_q   <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      t_q     <= t_d;
      w_q     <= w_d;
      new_q   <= new_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: a behavioural perceptron_dp plus an epoch-level training model.
// Directed sets cover separable, learning and XOR cases; random sets exercise the handshake and the x==0 / sign boundaries.
module tb_perceptron_trainer;
  localparam int EPOCH_LEN  = 4;
  localparam int MAX_EPOCHS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start_i = 1'b0, smp_valid_i = 1'b0, smp_t_i = 1'b0;
  logic [7:0] smp_x0_i = '0, smp_x1_i = '0;
  logic       smp_ready_o, enable_o, b_o, W0_o, W1_o, busy_o, converged_o, Y_i;
  logic [1:0] W1W0b_en_o;
  logic [7:0] X0_o, X1_o, err_cnt_o;
  logic [4:0] epoch_cnt_o;

  always #5 clk = ~clk;

  perceptron_trainer #(.WIDTH(8), .DP_LATENCY(1), .EPOCH_LEN(EPOCH_LEN),
                       .MAX_EPOCHS(MAX_EPOCHS), .INIT_W1W0B(3'b111)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .smp_valid_i(smp_valid_i),
    .smp_ready_o(smp_ready_o), .smp_x0_i(smp_x0_i), .smp_x1_i(smp_x1_i),
    .smp_t_i(smp_t_i), .enable_o(enable_o), .W1W0b_en_o(W1W0b_en_o),
    .b_o(b_o), .W0_o(W0_o), .W1_o(W1_o), .X0_o(X0_o), .X1_o(X1_o), .Y_i(Y_i),
    .busy_o(busy_o), .converged_o(converged_o), .epoch_cnt_o(epoch_cnt_o),
    .err_cnt_o(err_cnt_o)
  );

  // Datapath stand-in: weights follow the load strobes, Y is registered on enable and held.
  logic [2:0] dp_w = 3'b000;
  logic       dp_y = 1'b0;
  assign Y_i = dp_y;

  function automatic logic dp_eval(input logic [2:0] w, input logic [7:0] x0, input logic [7:0] x1);
    int s;
    s = (w[2] ? int'($signed(x1)) : -int'($signed(x1)))
      + (w[1] ? int'($signed(x0)) : -int'($signed(x0)))
      + (w[0] ? 1 : -1);
    return s >= 0;
  endfunction

  always @(posedge clk) begin
    case (W1W0b_en_o)
      2'b01:   dp_w[0] <= b_o;
      2'b10:   dp_w[1] <= W0_o;
      2'b11:   dp_w[2] <= W1_o;
      default: ;
    endcase
    if (enable_o) dp_y <= dp_eval(dp_w, X0_o, X1_o);
  end

  int         excl_viol = 0, x_viol = 0;
  logic       hold_act = 1'b0;
  logic [7:0] hx0 = '0, hx1 = '0;
  always @(negedge clk) begin
    if (!reset && enable_o && W1W0b_en_o != 2'b00) excl_viol <= excl_viol + 1;
    if (reset || smp_ready_o || !busy_o) hold_act <= 1'b0;
    else if (enable_o) begin
      hold_act <= 1'b1; hx0 <= X0_o; hx1 <= X1_o;
    end else if (hold_act && (X0_o != hx0 || X1_o != hx1)) x_viol <= x_viol + 1;
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: weights as +/-1 integers.
  int         mw0 = 1, mw1 = 1, mb = 1;
  logic [7:0] sx0 [EPOCH_LEN];
  logic [7:0] sx1 [EPOCH_LEN];
  logic       st  [EPOCH_LEN];
  logic       abort = 1'b0;

  function automatic logic [7:0] pick_x();
    case ($urandom_range(0, 6))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'h7F;
      3: return 8'hFF;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic load_set(input int a0, input int a1, input int at, input int k);
    sx0[k] = 8'(a0); sx1[k] = 8'(a1); st[k] = at[0];
  endtask

  task automatic drive_sample(input int k);
    smp_x0_i = sx0[k]; smp_x1_i = sx1[k]; smp_t_i = st[k];
  endtask

  // Called at a negedge with reset low; leaves the DUT idle after the initial loads.
  task automatic reset_and_check();
    logic [5:0] exp_ld;
    reset = 1'b1; start_i = 1'b0; smp_valid_i = 1'b0;
    @(negedge clk);
    check("rst_strobes", 32'({enable_o, W1W0b_en_o, b_o, W0_o, W1_o, busy_o, smp_ready_o, converged_o}), 32'd0);
    check("rst_x", 32'({X0_o, X1_o}), 32'd0);
    check("rst_cnt", 32'({epoch_cnt_o, err_cnt_o}), 32'd0);
    reset = 1'b0;
    mw0 = 1; mw1 = 1; mb = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) #1; else @(negedge clk);
      exp_ld = {2'(k + 1), 3'(3'b100 >> k), 1'b0};
      check("init_load", 32'({W1W0b_en_o, b_o, W0_o, W1_o, enable_o}), 32'(exp_ld));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle", 32'({busy_o, smp_ready_o, W1W0b_en_o, enable_o}), 32'd0);
    end
    check("dp_w_init", 32'(dp_w), 32'd7);
  endtask

  // Full training run from IDLE or DONE, checked sample by sample against the model.
  task automatic run_set();
    int  i, ni, to, lc, exp_loads, epoch, errs, s, nb, nw0, nw1;
    logic y, conv, done, glitch;
    if (abort) return;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start", 32'({smp_ready_o, converged_o, epoch_cnt_o, err_cnt_o}), 32'h4000);
    epoch = 0; errs = 0; conv = 1'b0; done = 1'b0; i = 0;
    drive_sample(0);
    smp_valid_i = 1'b1;
    while (!done) begin
      if ($urandom_range(0, 3) == 0) begin
        smp_valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        smp_valid_i = 1'b1;
      end
      to = 0;
      while (!smp_ready_o && to < 100) begin @(negedge clk); to++; end
      if (!smp_ready_o) begin check("timeout_ready", 32'd1, 32'd0); abort = 1'b1; break; end
      @(negedge clk);
      check("x_latched", 32'({X0_o, X1_o}), 32'({sx0[i], sx1[i]}));

      s = mw1 * int'($signed(sx1[i])) + mw0 * int'($signed(sx0[i])) + mb;
      y = (s >= 0);
      exp_loads = 0;
      if (y != st[i]) begin
        errs = (errs < 255) ? errs + 1 : errs;
        nb  = st[i] ? 1 : -1;
        nw0 = ((int'($signed(sx0[i])) >= 0) == st[i]) ? 1 : -1;
        nw1 = ((int'($signed(sx1[i])) >= 0) == st[i]) ? 1 : -1;
        exp_loads = int'(nb != mb) + int'(nw0 != mw0) + int'(nw1 != mw1);
        mb = nb; mw0 = nw0; mw1 = nw1;
      end
      if (i == EPOCH_LEN - 1) begin
        epoch++;
        if (errs == 0) begin conv = 1'b1; done = 1'b1; end
        else if (epoch == MAX_EPOCHS) done = 1'b1;
        else errs = 0;
      end
      ni = (i + 1) % EPOCH_LEN;
      drive_sample(ni);

      glitch = ($urandom_range(0, 3) == 0);
      lc = 0; to = 0;
      while (!smp_ready_o && busy_o && to < 100) begin
        if (W1W0b_en_o != 2'b00) lc++;
        start_i = glitch && (to == 1);
        @(negedge clk);
        to++;
      end
      start_i = 1'b0;
      if (to >= 100) begin check("timeout_sample", 32'd1, 32'd0); abort = 1'b1; break; end
      check("loads", 32'(lc), 32'(exp_loads));
      check("err_cnt", 32'(err_cnt_o), 32'(errs));
      check("epoch_cnt", 32'(epoch_cnt_o), 32'(epoch));
      check("busy", 32'(busy_o), 32'(!done));
      i = ni;
    end
    smp_valid_i = 1'b0;
    if (!abort) begin
      check("converged", 32'(converged_o), 32'(conv));
      check("done_ready", 32'(smp_ready_o), 32'd0);
      check("weights", 32'(dp_w), 32'({mw1 > 0, mw0 > 0, mb > 0}));
    end
  endtask

  task automatic random_set();
    for (int k = 0; k < EPOCH_LEN; k++) begin
      sx0[k] = pick_x(); sx1[k] = pick_x(); st[k] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    @(negedge clk);
    reset_and_check();

    load_set(20, 30, 1, 0); load_set(-20, 30, 1, 1); load_set(-50, -50, 0, 2); load_set(0, 0, 1, 3);
    run_set();
    load_set(30, 40, 0, 0); load_set(-50, -50, 1, 1); load_set(-10, -20, 1, 2); load_set(60, 10, 0, 3);
    run_set();
    load_set(-50, -50, 0, 0); load_set(-50, 50, 1, 1); load_set(50, -50, 1, 2); load_set(50, 50, 0, 3);
    run_set();
    for (int r = 0; r < 4; r++) begin random_set(); run_set(); end

    // Abandon a sample while the datapath is evaluating it.
    if (!abort) begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      load_set(-20, 30, 1, 0);
      drive_sample(0);
      smp_valid_i = 1'b1;
      @(negedge clk);
      smp_valid_i = 1'b0;
      check("eval", 32'({busy_o, enable_o}), 32'd3);
      @(negedge clk);
      check("wait", 32'({busy_o, enable_o, smp_ready_o}), 32'd4);
      reset_and_check();
    end

    for (int r = 0; r < 2; r++) begin random_set(); run_set(); end

    check("enable_load_exclusive", 32'(excl_viol), 32'd0);
    check("x_stable", 32'(x_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
